// File: rtl/count_match_monitor.sv
// Watches an upstream counter value, counts arrivals at a latched target and
// flags all-ones to zero wrap-around of the counter.
module count_match_monitor #(
    parameter int WIDTH  = 4,
    parameter int HITS_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  target,
    input  logic [HITS_W-1:0] goal,
    input  logic              arm,
    input  logic              clear,
    output logic [HITS_W-1:0] hits,
    output logic              match_pulse,
    output logic              wrap_pulse,
    output logic              done,
    output logic              busy,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  target_q;
    logic [HITS_W-1:0] goal_q;
    logic [WIDTH-1:0]  prev_a;
    logic              prev_valid;

    // One extra bit so the goal comparison and saturation never see a wrapped count.
    logic [HITS_W:0]   hits_inc;
    logic [HITS_W-1:0] hits_sat;
    logic              goal_hit;
    logic              is_match;
    logic              wrap_seen;

    assign hits_inc  = {1'b0, hits} + {{HITS_W{1'b0}}, 1'b1};
    assign hits_sat  = hits_inc[HITS_W] ? hits : hits_inc[HITS_W-1:0];
    assign goal_hit  = (hits_inc >= {1'b0, goal_q});
    assign is_match  = en && (A == target_q);
    assign wrap_seen = en && prev_valid && (prev_a == {WIDTH{1'b1}}) && (A == {WIDTH{1'b0}});

    assign busy  = (state_q == ARMED) || (state_q == HOLD);
    assign state = state_q;

    // en only qualifies A; there is no back-pressure, a sample is taken on every en=1 edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            hits        <= '0;
            match_pulse <= 1'b0;
            wrap_pulse  <= 1'b0;
            done        <= 1'b0;
            target_q    <= '0;
            goal_q      <= '0;
            prev_a      <= '0;
            prev_valid  <= 1'b0;
        end else begin
            match_pulse <= 1'b0;
            wrap_pulse  <= wrap_seen;

            // Wrap history survives en=0 gaps; only clear forgets it.
            if (clear) begin
                prev_valid <= 1'b0;
            end else if (en) begin
                prev_a     <= A;
                prev_valid <= 1'b1;
            end

            if (clear) begin
                state_q <= IDLE;
                hits    <= '0;
                done    <= 1'b0;
            end else if (arm) begin
                target_q <= target;
                goal_q   <= (goal == '0) ? {{(HITS_W-1){1'b0}}, 1'b1} : goal;
                hits     <= '0;
                done     <= 1'b0;
                state_q  <= ARMED;
            end else begin
                case (state_q)
                    ARMED: begin
                        if (is_match) begin
                            hits        <= hits_sat;
                            match_pulse <= 1'b1;
                            if (goal_hit) begin
                                state_q <= DONE;
                                done    <= 1'b1;
                            end else begin
                                state_q <= HOLD;
                            end
                        end
                    end
                    // A counter parked on the target must move away before it can count again.
                    HOLD: begin
                        if (en && (A != target_q)) state_q <= ARMED;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_match_monitor.sv
// Directed bench for count_match_monitor: one task per scenario, inline checks.
module tb_count_match_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] A;
    logic [3:0] target;
    logic [7:0] goal;
    logic [1:0] goal2;
    logic       arm;
    logic       clear;

    logic [7:0] hits;
    logic       match_pulse, wrap_pulse, done, busy;
    logic [1:0] state;

    logic [1:0] hits2;
    logic       match2, wrap2, done2, busy2;
    logic [1:0] state2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    count_match_monitor #(.WIDTH(4), .HITS_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .A(A), .target(target), .goal(goal),
        .arm(arm), .clear(clear), .hits(hits), .match_pulse(match_pulse),
        .wrap_pulse(wrap_pulse), .done(done), .busy(busy), .state(state)
    );

    count_match_monitor #(.WIDTH(4), .HITS_W(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .A(A), .target(target), .goal(goal2),
        .arm(arm), .clear(clear), .hits(hits2), .match_pulse(match2),
        .wrap_pulse(wrap2), .done(done2), .busy(busy2), .state(state2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm(input logic [3:0] t, input logic [7:0] g);
        target = t; goal = g; arm = 1'b1; en = 1'b0;
        tick();
        arm = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b0; A = 4'd0; target = 4'd0; goal = 8'd0; goal2 = 2'd0;
        arm = 1'b0; clear = 1'b0;
        tick(); tick();
        reset = 1'b1;
        n_checks++;
        if ({state, hits, match_pulse, wrap_pulse, done, busy} !== 14'd0)
            $display("FAIL reset_state got=%h exp=0", {state, hits, match_pulse, wrap_pulse, done, busy});
        else n_pass++;
    endtask

    task automatic test_basic_match();
        logic [12:0] got, exp;
        logic [1:0]  es;
        logic [7:0]  eh;
        do_arm(4'd5, 8'd2);
        n_checks++;
        if (state !== 2'd1 || busy !== 1'b1 || hits !== 8'd0)
            $display("FAIL arm_basic state=%0d busy=%0b hits=%0d exp 1/1/0", state, busy, hits);
        else n_pass++;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < 16; a++) begin
                A = 4'(a); en = 1'b1;
                tick();
                if (p == 0) begin
                    es = (a == 5) ? 2'd2 : 2'd1;
                    eh = (a < 5) ? 8'd0 : 8'd1;
                end else begin
                    es = (a < 5) ? 2'd1 : 2'd3;
                    eh = (a < 5) ? 8'd1 : 8'd2;
                end
                exp = {es, eh, 1'(a == 5), 1'(p == 1 && a == 0), 1'(p == 1 && a >= 5)};
                got = {state, hits, match_pulse, wrap_pulse, done};
                n_checks++;
                if (got !== exp)
                    $display("FAIL basic p=%0d a=%0d got=%h exp=%h", p, a, got, exp);
                else n_pass++;
            end
        end
    endtask

    task automatic test_parked();
        logic [1:0] es;
        do_arm(4'd3, 8'd4);
        n_checks++;
        if (state !== 2'd1 || hits !== 8'd0 || done !== 1'b0)
            $display("FAIL parked_arm state=%0d hits=%0d done=%0b exp 1/0/0", state, hits, done);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            A = 4'd3; en = 1'b1;
            tick();
            n_checks++;
            if (state !== 2'd2 || hits !== 8'd1 || match_pulse !== (i == 0))
                $display("FAIL parked_hold i=%0d state=%0d hits=%0d mp=%0b exp 2/1/%0b",
                         i, state, hits, match_pulse, (i == 0));
            else n_pass++;
        end
        A = 4'd4;
        tick();
        n_checks++;
        if (state !== 2'd1 || hits !== 8'd1 || match_pulse !== 1'b0)
            $display("FAIL parked_leave state=%0d hits=%0d mp=%0b exp 1/1/0", state, hits, match_pulse);
        else n_pass++;
        A = 4'd3;
        tick();
        es = 2'd2;
        n_checks++;
        if (state !== es || hits !== 8'd2 || match_pulse !== 1'b1)
            $display("FAIL parked_return state=%0d hits=%0d mp=%0b exp 2/2/1", state, hits, match_pulse);
        else n_pass++;
    endtask

    task automatic test_clear_arm();
        do_arm(4'd3, 8'd4);
        A = 4'd3; en = 1'b1;
        tick();
        n_checks++;
        if (state !== 2'd2 || hits !== 8'd1)
            $display("FAIL ca_setup state=%0d hits=%0d exp 2/1", state, hits);
        else n_pass++;
        clear = 1'b1; arm = 1'b1;
        tick();
        clear = 1'b0; arm = 1'b0;
        n_checks++;
        if (state !== 2'd0 || hits !== 8'd0 || done !== 1'b0 || busy !== 1'b0)
            $display("FAIL clear_priority state=%0d hits=%0d done=%0b busy=%0b exp 0/0/0/0",
                     state, hits, done, busy);
        else n_pass++;
        A = 4'd3; en = 1'b1;
        tick();
        n_checks++;
        if (state !== 2'd0 || match_pulse !== 1'b0 || hits !== 8'd0)
            $display("FAIL idle_no_match state=%0d mp=%0b hits=%0d exp 0/0/0", state, match_pulse, hits);
        else n_pass++;
        do_arm(4'd3, 8'd4);
        n_checks++;
        if (state !== 2'd1 || busy !== 1'b1)
            $display("FAIL rearm state=%0d busy=%0b exp 1/1", state, busy);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [3:0] seq_a [10];
        logic       seq_en[10];
        logic       seq_w [10];
        seq_a  = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd14, 4'd15, 4'd9, 4'd0, 4'd15, 4'd1};
        seq_en = '{1'b1,  1'b1,  1'b1, 1'b1, 1'b1,  1'b1,  1'b0, 1'b1, 1'b1,  1'b1};
        seq_w  = '{1'b0,  1'b0,  1'b1, 1'b0, 1'b0,  1'b0,  1'b0, 1'b1, 1'b0,  1'b0};
        for (int i = 0; i < 10; i++) begin
            A = seq_a[i]; en = seq_en[i];
            tick();
            n_checks++;
            if (wrap_pulse !== seq_w[i])
                $display("FAIL wrap step=%0d got=%0b exp=%0b", i, wrap_pulse, seq_w[i]);
            else n_pass++;
        end
        A = 4'd15; en = 1'b1;
        tick();
        clear = 1'b1; en = 1'b0;
        tick();
        clear = 1'b0; A = 4'd0; en = 1'b1;
        tick();
        n_checks++;
        if (wrap_pulse !== 1'b0)
            $display("FAIL wrap_after_clear got=%0b exp=0", wrap_pulse);
        else n_pass++;
    endtask

    task automatic test_goal_zero();
        goal2 = 2'd0;
        do_arm(4'd7, 8'd0);
        A = 4'd7; en = 1'b1;
        tick();
        n_checks++;
        if (state !== 2'd3 || done !== 1'b1 || hits !== 8'd1 || match_pulse !== 1'b1)
            $display("FAIL goal_zero state=%0d done=%0b hits=%0d mp=%0b exp 3/1/1/1",
                     state, done, hits, match_pulse);
        else n_pass++;
        tick();
        n_checks++;
        if (state !== 2'd3 || hits !== 8'd1 || match_pulse !== 1'b0 || done !== 1'b1)
            $display("FAIL goal_zero_frozen state=%0d hits=%0d mp=%0b done=%0b exp 3/1/0/1",
                     state, hits, match_pulse, done);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [5:0] got, exp;
        goal2 = 2'd3;
        do_arm(4'd7, 8'd10);
        for (int k = 1; k <= 5; k++) begin
            A = 4'd7; en = 1'b1;
            tick();
            if (k <= 2)      exp = {2'd2, 2'(k), 1'b1, 1'b0};
            else if (k == 3) exp = {2'd3, 2'd3, 1'b1, 1'b1};
            else             exp = {2'd3, 2'd3, 1'b0, 1'b1};
            got = {state2, hits2, match2, done2};
            n_checks++;
            if (got !== exp)
                $display("FAIL sat_match k=%0d got=%h exp=%h", k, got, exp);
            else n_pass++;
            A = 4'd0;
            tick();
        end
        n_checks++;
        if (hits !== 8'd5 || done !== 1'b0)
            $display("FAIL sat_wide hits=%0d done=%0b exp 5/0", hits, done);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        do_arm(4'd5, 8'd4);
        en = 1'b1;
        A = 4'd5; tick();
        A = 4'd6; tick();
        A = 4'd5; tick();
        A = 4'd6; tick();
        A = 4'd15; tick();
        n_checks++;
        if (state !== 2'd1 || hits !== 8'd2)
            $display("FAIL ar_setup state=%0d hits=%0d exp 1/2", state, hits);
        else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({state, hits, match_pulse, wrap_pulse, done, busy} !== 14'd0)
            $display("FAIL async_reset got=%h exp=0", {state, hits, match_pulse, wrap_pulse, done, busy});
        else n_pass++;
        tick();
        reset = 1'b1;
        A = 4'd0; en = 1'b1;
        tick();
        n_checks++;
        if (wrap_pulse !== 1'b0 || state !== 2'd0)
            $display("FAIL post_reset_wrap wrap=%0b state=%0d exp 0/0", wrap_pulse, state);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_match();
        test_parked();
        test_clear_arm();
        test_wrap();
        test_goal_zero();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
